fetch_unit: RTL and testbench

- Instruction fetch stage, directly upstream of the decode stage that extracts immediates from the 32-bit instruction word.
- Owns the program counter and issues in-order word requests to instruction memory.
- Buffers returned instructions in a small FIFO and presents {inst, pc} to decode through a valid/ready handshake.
- Accepts redirects from branch/jump resolution and squashes wrong-path fetches still in flight.

---
 rtl/rv_pkg.sv | 38 +++
 rtl/fetch_fifo.sv | 106 ++++++++++
 rtl/fetch_unit.sv | 162 ++++++++++++++++
 tb/tb_fetch_unit.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// ---------------------------------------------------------------------------
// rv_pkg
// Shared RISC-V front-end definitions used by the fetch stage and by decode.
//   - Major opcode constants used by immediate extraction in decode.
//   - INST_NOP: canonical "addi x0, x0, 0" presented while nothing is fetched.
//   - DEFAULT_RESET_PC: default program counter after reset.
//   - fetch_entry_t: one buffered instruction together with its PC.
//   - fetch_state_e: fetch control state (normal run / squashing wrong path).
// ---------------------------------------------------------------------------
package rv_pkg;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;

  // addi x0, x0, 0 -> 32'h0000_0013
  localparam logic [31:0] INST_NOP = {12'h000, 5'd0, 3'b000, 5'd0, OPC_OP_IMM};

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_SQUASH = 1'b1
  } fetch_state_e;

  // Force an address onto a word boundary (low two bits cleared).
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// ---------------------------------------------------------------------------
// fetch_fifo
// Synchronous FIFO of fetch_entry_t used as the fetch-to-decode buffer.
// The head entry is held in a register so the decode-facing outputs come
// straight from flops; a word pushed into an empty FIFO shows up on head
// one cycle later.
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset (empties FIFO, head = RESET_HEAD)
//   push       in   write push_data at the tail
//   push_data  in   entry to write
//   pop        in   remove the head entry (ignored when empty)
//   flush      in   discard all entries this cycle (push ignored, head holds)
//   count      out  number of valid entries, 0..DEPTH
//   head       out  registered copy of the oldest entry
// ---------------------------------------------------------------------------
module fetch_fifo
  import rv_pkg::*;
#(
  parameter int           DEPTH      = 4,
  parameter fetch_entry_t RESET_HEAD = '{pc: DEFAULT_RESET_PC, inst: INST_NOP},
  localparam int          AW         = $clog2(DEPTH),
  localparam int          CW         = AW + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  input  logic         flush,
  output logic [CW-1:0] count,
  output fetch_entry_t head
);

  fetch_entry_t  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW-1:0] rd_ptr_inc;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  fetch_entry_t  head_q;
  fetch_entry_t  head_d;
  logic          pop_eff;

  assign pop_eff    = pop && (count_q != '0);
  assign rd_ptr_inc = rd_ptr_q + AW'(1);

  always_comb begin
    count_d = count_q;
    unique case ({push, pop_eff})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Next head: an incoming word becomes head when it lands in a FIFO that is
  // (or is about to become) empty; otherwise a pop exposes the next stored
  // entry. When nothing is valid the last head is simply held.
  always_comb begin
    head_d = head_q;
    if (push && ((count_q == '0) || (pop_eff && (count_q == CW'(1))))) begin
      head_d = push_data;
    end else if (pop_eff && (count_q > CW'(1))) begin
      head_d = mem_q[rd_ptr_inc];
    end
  end

  // Storage array without reset so it can map onto distributed/block RAM.
  always_ff @(posedge clk) begin
    if (!rst && !flush && push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= RESET_HEAD;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop_eff) begin
        rd_ptr_q <= rd_ptr_inc;
      end
      count_q <= count_d;
      head_q  <= head_d;
    end
  end

  assign count = count_q;
  assign head  = head_q;

  // The producer's credit scheme must never push into a full FIFO.
  a_no_overflow : assert property (@(posedge clk) disable iff (rst)
    !(push && !flush && !pop_eff && (count_q == CW'(DEPTH))));

endmodule

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
// Instruction fetch stage. Owns the PC, issues in-order word requests to
// instruction memory, buffers returned words and hands {inst, pc} to decode.
// A redirect flushes the buffer, restarts fetch at the new target and marks
// every request still in flight so its response is dropped on arrival.
//
// Requests are credit-limited: outstanding + buffered never exceeds
// FIFO_DEPTH, so every response has a guaranteed FIFO slot.
//
// Ports:
//   clk             in   clock, rising edge
//   rst             in   synchronous active-high reset
//   imem_req_valid  out  fetch request valid
//   imem_req_ready  in   memory accepts request
//   imem_req_addr   out  word-aligned fetch address (current fetch PC)
//   imem_rsp_valid  in   in-order response, latency >= 1, never stalled
//   imem_rsp_data   in   returned instruction word
//   redirect_valid  in   control-flow change this cycle
//   redirect_pc     in   new fetch target (low bits ignored)
//   inst_valid      out  instruction available to decode
//   inst_ready      in   decode accepts
//   inst            out  instruction word (NOP after reset)
//   inst_pc         out  PC of inst
// ---------------------------------------------------------------------------
module fetch_unit
  import rv_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc
);

  localparam int          CW         = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0] CREDIT_CAP = (CW + 1)'(FIFO_DEPTH);

  fetch_state_e  state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   rsp_pc_q, rsp_pc_d;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] drop_cnt_q, drop_cnt_d;

  logic          credit_ok;
  logic          req_fire;
  logic          inst_pop;
  logic          fifo_push;
  logic          fifo_flush;
  logic [CW-1:0] fifo_count;
  fetch_entry_t  fifo_push_data;
  fetch_entry_t  fifo_head;
  logic [31:0]   redirect_target;

  // ------------------------------------------------------------------------
  // Handshake outputs. A redirect cycle suppresses both sides so neither a
  // wrong-path request nor a stale instruction escapes.
  // ------------------------------------------------------------------------
  always_comb begin
    credit_ok      = ({1'b0, outstanding_q} + {1'b0, fifo_count}) < CREDIT_CAP;
    imem_req_valid = !rst && !redirect_valid && credit_ok;
    inst_valid     = !rst && !redirect_valid && (fifo_count != '0);
  end

  assign imem_req_addr   = fetch_pc_q;
  assign req_fire        = imem_req_valid && imem_req_ready;
  assign inst_pop        = inst_valid && inst_ready;
  assign redirect_target = align_word(redirect_pc);
  assign fifo_push_data  = '{pc: rsp_pc_q, inst: imem_rsp_data};

  // ------------------------------------------------------------------------
  // Next-state logic. Responses arriving while drop_cnt is non-zero belong
  // to a squashed path; they consume outstanding credit but are not kept.
  // ------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    rsp_pc_d      = rsp_pc_q;
    drop_cnt_d    = drop_cnt_q;
    fifo_push     = 1'b0;
    fifo_flush    = 1'b0;
    outstanding_d = outstanding_q + CW'(req_fire) - CW'(imem_rsp_valid);

    if (req_fire) begin
      fetch_pc_d = fetch_pc_q + 32'd4;
    end

    if (redirect_valid) begin
      // Everything still in flight after this edge is wrong-path; a response
      // landing in this very cycle is already excluded from outstanding_d
      // and is thrown away together with the flushed FIFO contents.
      fetch_pc_d = redirect_target;
      rsp_pc_d   = redirect_target;
      fifo_flush = 1'b1;
      drop_cnt_d = outstanding_d;
      state_d    = (outstanding_d != '0) ? ST_SQUASH : ST_RUN;
    end else if (imem_rsp_valid) begin
      unique case (state_q)
        ST_RUN: begin
          fifo_push = 1'b1;
          rsp_pc_d  = rsp_pc_q + 32'd4;
        end
        ST_SQUASH: begin
          drop_cnt_d = drop_cnt_q - CW'(1);
          if (drop_cnt_q == CW'(1)) begin
            state_d = ST_RUN;
          end
        end
        default: state_d = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_RUN;
      fetch_pc_q    <= RESET_PC;
      rsp_pc_q      <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      rsp_pc_q      <= rsp_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

  fetch_fifo #(
    .DEPTH      (FIFO_DEPTH),
    .RESET_HEAD ('{pc: RESET_PC, inst: INST_NOP})
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (fifo_push_data),
    .pop       (inst_pop),
    .flush     (fifo_flush),
    .count     (fifo_count),
    .head      (fifo_head)
  );

  assign inst    = fifo_head.inst;
  assign inst_pc = fifo_head.pc;

  // Memory responses only ever answer requests this unit issued.
  a_rsp_has_credit : assert property (@(posedge clk) disable iff (rst)
    imem_rsp_valid |-> (outstanding_q != '0));

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
// Self-checking bench for fetch_unit: directed scenarios with literal
// expectations followed by a randomized run. A queue-based model predicts
// handshakes, fetch addresses and the instruction stream seen by decode.
// ---------------------------------------------------------------------------
module tb_fetch_unit;
  import rv_pkg::*;

  localparam int          DEPTH  = 4;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;

  fetch_unit #(.RESET_PC(RST_PC), .FIFO_DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc)
  );

  initial forever #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // ---------------- model state ----------------
  typedef struct { logic [31:0] addr; bit discard; } flight_t;
  typedef struct { logic [31:0] data; int due; } mresp_t;

  flight_t      m_infl[$];    // requests in flight, oldest first
  fetch_entry_t m_fifo[$];    // instructions waiting for decode
  logic [31:0]  m_fetch_pc;

  mresp_t      mem_q[$];
  int          cyc      = 0;
  int          last_due = 0;
  int          lat_min  = 1;
  int          lat_max  = 1;
  bit          cap_fire = 1'b0;
  logic [31:0] cap_addr = '0;
  bit          cmp_en   = 1'b0;

  // Instruction memory contents: a fixed function of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [6:0] op;
    int sel;
    sel = int'(a[6:2]) % 5;
    case (sel)
      0:       op = OPC_OP_IMM;
      1:       op = OPC_LOAD;
      2:       op = OPC_STORE;
      3:       op = OPC_BRANCH;
      default: op = OPC_LUI;
    endcase
    return {a[26:2] ^ 25'h0A5C3F1, op};
  endfunction

  function automatic bit m_req_valid();
    return (rst === 1'b0) && (redirect_valid === 1'b0) &&
           (m_infl.size() + m_fifo.size() < DEPTH);
  endfunction

  function automatic bit m_inst_valid();
    return (rst === 1'b0) && (redirect_valid === 1'b0) && (m_fifo.size() > 0);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h, expected %08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chkb(input string name, input logic act, input logic exp);
    chk(name, {31'b0, act}, {31'b0, exp});
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    cap_fire = (imem_req_valid === 1'b1) && (imem_req_ready === 1'b1);
    cap_addr = imem_req_addr;
    if (cmp_en) begin
      chkb("req_valid", imem_req_valid, m_req_valid());
      if (m_req_valid()) chk("req_addr", imem_req_addr, m_fetch_pc);
      chkb("inst_valid", inst_valid, m_inst_valid());
      if (m_inst_valid()) begin
        chk("inst_pc", inst_pc, m_fifo[0].pc);
        chk("inst", inst, m_fifo[0].inst);
        if (inst_ready) $display("xfer pc=%08h inst=%08h", inst_pc, inst);
      end
    end
  end

  // ---------------- model + memory update at the clock edge ----------------
  task automatic model_step();
    bit           fire, pop;
    int           lat, due;
    flight_t      f;
    fetch_entry_t e;
    fire = m_req_valid() && (imem_req_ready === 1'b1);
    pop  = m_inst_valid() && (inst_ready === 1'b1);
    cyc++;
    if (rst) begin
      m_infl.delete();
      m_fifo.delete();
      mem_q.delete();
      m_fetch_pc = RST_PC;
      last_due   = 0;
      return;
    end
    if (cap_fire) begin
      lat = $urandom_range(lat_max, lat_min);
      due = cyc + lat - 1;
      if (due <= last_due) due = last_due + 1;
      mem_q.push_back('{data: mem_word(cap_addr), due: due});
      last_due = due;
    end
    if (redirect_valid) begin
      if (imem_rsp_valid && m_infl.size() > 0) f = m_infl.pop_front();
      foreach (m_infl[i]) m_infl[i].discard = 1'b1;
      m_fifo.delete();
      m_fetch_pc = redirect_pc & ~32'h3;
    end else begin
      if (pop) e = m_fifo.pop_front();
      if (imem_rsp_valid && m_infl.size() > 0) begin
        f = m_infl.pop_front();
        if (!f.discard) m_fifo.push_back('{pc: f.addr, inst: mem_word(f.addr)});
      end
      if (fire) begin
        m_infl.push_back('{addr: m_fetch_pc, discard: 1'b0});
        m_fetch_pc = m_fetch_pc + 32'd4;
      end
    end
  endtask

  task automatic mem_drive();
    mresp_t r;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'hDEAD_BEEF;
    if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      r = mem_q.pop_front();
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = r.data;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    mem_drive();
  endtask

  task automatic at_sample();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    redirect_valid = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Wait (bounded) for the first instruction after a redirect and check its PC.
  task automatic wait_first_pc(input string name, input logic [31:0] exp);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      at_sample();
      if (!found && inst_valid === 1'b1) begin
        chk(name, inst_pc, exp);
        found = 1'b1;
      end
      tick();
    end
    chkb({name, "_seen"}, found, 1'b1);
  endtask

  initial begin
    bit reached;
    rst            = 1'b1;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    inst_ready     = 1'b1;
    m_fetch_pc     = RST_PC;

    // ---- reset then streaming, memory latency 1 ----
    lat_min = 1; lat_max = 1;
    tick();
    cmp_en = 1'b1;
    at_sample();
    chkb("rst_inst_valid", inst_valid, 1'b0);
    chkb("rst_req_valid", imem_req_valid, 1'b0);
    chk("rst_inst", inst, 32'h0000_0013);
    chk("rst_inst_pc", inst_pc, 32'h0000_0000);
    tick();
    rst = 1'b0;
    at_sample();
    chkb("start_req_valid", imem_req_valid, 1'b1);
    chk("start_addr0", imem_req_addr, 32'h0);
    chkb("start_inst_valid0", inst_valid, 1'b0);
    tick();
    at_sample();
    chk("start_addr1", imem_req_addr, 32'h4);
    chkb("start_inst_valid1", inst_valid, 1'b0);
    tick();
    for (int k = 2; k < 8; k++) begin
      at_sample();
      chk("stream_addr", imem_req_addr, 32'(4 * k));
      chkb("stream_valid", inst_valid, 1'b1);
      chk("stream_pc", inst_pc, 32'(4 * (k - 2)));
      chk("stream_inst", inst, mem_word(32'(4 * (k - 2))));
      tick();
    end

    // ---- backpressure ----
    inst_ready = 1'b0;
    do_reset();
    repeat (10) tick();
    at_sample();
    chkb("bp_inst_valid", inst_valid, 1'b1);
    chk("bp_hold_pc", inst_pc, 32'h0);
    chkb("bp_req_stall", imem_req_valid, 1'b0);
    tick();
    inst_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      at_sample();
      chkb("bp_rel_valid", inst_valid, 1'b1);
      chk("bp_rel_pc", inst_pc, 32'(4 * k));
      tick();
    end

    // ---- squash with two requests in flight (latency 3) ----
    lat_min = 3; lat_max = 3;
    do_reset();
    tick();
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0100;
    at_sample();
    chkb("redir_req_valid", imem_req_valid, 1'b0);
    chkb("redir_inst_valid", inst_valid, 1'b0);
    tick();
    redirect_valid = 1'b0;
    at_sample();
    chkb("squash_req_valid", imem_req_valid, 1'b1);
    chk("squash_addr", imem_req_addr, 32'h0000_0100);
    tick();
    wait_first_pc("squash_first_pc", 32'h0000_0100);

    // ---- misaligned redirect ----
    lat_min = 1; lat_max = 1;
    do_reset();
    repeat (3) tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0102;
    tick();
    redirect_valid = 1'b0;
    at_sample();
    chk("misalign_addr", imem_req_addr, 32'h0000_0100);
    tick();
    wait_first_pc("misalign_first_pc", 32'h0000_0100);

    // ---- reset with three instructions buffered ----
    inst_ready = 1'b0;
    do_reset();
    reached = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (!reached) begin
        tick();
        if (m_fifo.size() == 3) reached = 1'b1;
      end
    end
    chkb("midrst_three_buffered", reached, 1'b1);
    rst = 1'b1;
    tick();
    at_sample();
    chkb("midrst_inst_valid", inst_valid, 1'b0);
    chkb("midrst_req_valid", imem_req_valid, 1'b0);
    chk("midrst_inst", inst, 32'h0000_0013);
    chk("midrst_inst_pc", inst_pc, 32'h0000_0000);
    tick();
    rst = 1'b0;
    inst_ready = 1'b1;
    at_sample();
    chkb("midrst_resume_valid", imem_req_valid, 1'b1);
    chk("midrst_resume_addr", imem_req_addr, 32'h0);
    tick();

    // ---- randomized run ----
    for (int i = 0; i < 3000; i++) begin
      lat_min = 1;
      lat_max = (i < 1500) ? 2 : 5;
      imem_req_ready = ($urandom_range(3, 0) != 0);
      inst_ready     = ($urandom_range(3, 0) != 0);
      redirect_valid = ($urandom_range(19, 0) == 0);
      redirect_pc    = $urandom;
      rst            = ($urandom_range(299, 0) == 0);
      tick();
    end
    rst = 1'b0;
    redirect_valid = 1'b0;
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
